// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - word-addressed data memory initiator with sub-word read-modify-write
// Optional feature macro: LSU_MISALIGN_CHECK_EN (reject misaligned/reserved requests with rspError)
module load_store_unit #(
    parameter int ADDR_BITS = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 reqValid,
    output logic                 reqReady,
    input  logic                 reqWrite,
    input  logic [1:0]           reqSize,
    input  logic                 reqSigned,
    input  logic [ADDR_BITS-1:0] reqAddress,
    input  logic [31:0]          reqWriteData,
    output logic                 rspValid,
    input  logic                 rspReady,
    output logic [31:0]          rspData,
    output logic                 rspError,
    output logic [ADDR_BITS-1:0] dmAddress,
    output logic                 dmWriteEnabled,
    output logic [31:0]          dmWriteInput,
    input  logic [31:0]          dmReadResult
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [1:0]             size_q, size_d;
    logic                   signed_q, signed_d;
    logic                   write_q, write_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   error_q, error_d;

    logic                   req_invalid;
    logic [7:0]             byte_lane;
    logic [15:0]            half_lane;
    logic [31:0]            load_word;
    logic [31:0]            store_word;
    logic [ADDR_BITS-1:0]   word_addr;

    // Request legality; without the check every request is served and size 11 acts as a word
`ifdef LSU_MISALIGN_CHECK_EN
    always_comb begin
        req_invalid = 1'b0;
        case (reqSize)
            2'b01:   req_invalid = reqAddress[0];
            2'b10:   req_invalid = (reqAddress[1:0] != 2'b00);
            2'b11:   req_invalid = 1'b1;
            default: req_invalid = 1'b0;
        endcase
    end
`else
    assign req_invalid = 1'b0;
`endif

    // State and request-field registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            write_q  <= 1'b0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            error_q  <= error_d;
        end
    end

    // Next-state logic: accept in IDLE, fetch the word when needed, write once, hold the response
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        signed_d = signed_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        error_d  = error_q;
        case (state_q)
            IDLE: begin
                if (reqValid) begin
                    addr_d   = reqAddress;
                    size_d   = reqSize;
                    signed_d = reqSigned;
                    write_d  = reqWrite;
                    wdata_d  = reqWriteData;
                    error_d  = req_invalid;
                    if (req_invalid) begin
                        state_d = RESP;
                    end else if (reqWrite && reqSize[1]) begin
                        // full-word store needs no read of the old word
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                rdata_d = dmReadResult;
                state_d = write_q ? WRITE : RESP;
            end
            WRITE: begin
                state_d = RESP;
            end
            RESP: begin
                if (rspReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Little-endian lane selection from the registered read word
    always_comb begin
        byte_lane = rdata_q[7:0];
        case (addr_q[1:0])
            2'd0:    byte_lane = rdata_q[7:0];
            2'd1:    byte_lane = rdata_q[15:8];
            2'd2:    byte_lane = rdata_q[23:16];
            default: byte_lane = rdata_q[31:24];
        endcase
        half_lane = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    end

    // Load extension: word loads pass through, sub-word loads fill with sign or zero
    always_comb begin
        load_word = rdata_q;
        if (!size_q[1]) begin
            if (size_q[0]) begin
                load_word = {{16{signed_q & half_lane[15]}}, half_lane};
            end else begin
                load_word = {{24{signed_q & byte_lane[7]}}, byte_lane};
            end
        end
    end

    // Store merge: only the addressed lane(s) take new data, the rest keep the fetched bits
    always_comb begin
        store_word = rdata_q;
        if (size_q[1]) begin
            store_word = wdata_q;
        end else if (size_q[0]) begin
            if (addr_q[1]) begin
                store_word[31:16] = wdata_q[15:0];
            end else begin
                store_word[15:0]  = wdata_q[15:0];
            end
        end else begin
            case (addr_q[1:0])
                2'd0:    store_word[7:0]   = wdata_q[7:0];
                2'd1:    store_word[15:8]  = wdata_q[7:0];
                2'd2:    store_word[23:16] = wdata_q[7:0];
                default: store_word[31:24] = wdata_q[7:0];
            endcase
        end
    end

    // Memory side: address and data only driven while the unit owns the memory
    always_comb begin
        word_addr      = {addr_q[ADDR_BITS-1:2], 2'b00};
        dmAddress      = '0;
        dmWriteEnabled = 1'b0;
        dmWriteInput   = 32'd0;
        if (state_q == READ) begin
            dmAddress = word_addr;
        end else if (state_q == WRITE) begin
            dmAddress      = word_addr;
            dmWriteEnabled = 1'b1;
            dmWriteInput   = store_word;
        end
    end

    // Pipeline side handshakes and response payload, zero outside RESP
    always_comb begin
        reqReady = (state_q == IDLE);
        rspValid = (state_q == RESP);
        rspData  = 32'd0;
        if ((state_q == RESP) && !write_q && !error_q) begin
            rspData = load_word;
        end
    end

    // Error flag only exists when the legality check is built in
`ifdef LSU_MISALIGN_CHECK_EN
    assign rspError = (state_q == RESP) && error_q;
`else
    assign rspError = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [1:0]  reqSize;
    logic        reqSigned;
    logic [31:0] reqAddress;
    logic [31:0] reqWriteData;
    logic        rspValid;
    logic        rspReady;
    logic [31:0] rspData;
    logic        rspError;
    logic [31:0] dmAddress;
    logic        dmWriteEnabled;
    logic [31:0] dmWriteInput;
    logic [31:0] dmReadResult;

    load_store_unit #(.ADDR_BITS(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .reqValid       (reqValid),
        .reqReady       (reqReady),
        .reqWrite       (reqWrite),
        .reqSize        (reqSize),
        .reqSigned      (reqSigned),
        .reqAddress     (reqAddress),
        .reqWriteData   (reqWriteData),
        .rspValid       (rspValid),
        .rspReady       (rspReady),
        .rspData        (rspData),
        .rspError       (rspError),
        .dmAddress      (dmAddress),
        .dmWriteEnabled (dmWriteEnabled),
        .dmWriteInput   (dmWriteInput),
        .dmReadResult   (dmReadResult)
    );

    always #5 clock = ~clock;

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];

    assign dmReadResult = mem[dmAddress[7:2]];

    always @(posedge clock) begin
        if (dmWriteEnabled) mem[dmAddress[7:2]] <= dmWriteInput;
    end

    int cycle = 0;
    always @(posedge clock) cycle <= cycle + 1;

    int n_cmp  = 0;
    int n_fail = 0;
    bit started = 0;
    int accept_cycle = 0;

    logic [31:0] exp_rsp_data [$];
    logic        exp_rsp_err  [$];
    logic [31:0] exp_wr_addr  [$];
    logic [31:0] exp_wr_data  [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour of one request against the reference memory image
    function automatic void model(input logic wr, input logic [1:0] sz, input logic sg,
                                  input logic [31:0] a, input logic [31:0] d,
                                  input bit commit, output int lat);
        logic [31:0] w, v, mask;
        int idx, bo, sh;
        bit bad;
        idx = int'(a[7:2]);
        bo  = int'(a[1:0]);
        w   = ref_mem[idx];
        bad = 0;
`ifdef LSU_MISALIGN_CHECK_EN
        bad = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
`endif
        if (bad) begin
            exp_rsp_data.push_back(32'd0);
            exp_rsp_err.push_back(1'b1);
            lat = 1;
        end else if (!wr) begin
            if (sz >= 2'd2) begin
                v = w;
            end else if (sz == 2'd0) begin
                v = (w >> (8 * bo)) & 32'hFF;
                if (sg && v[7]) v = v | 32'hFFFF_FF00;
            end else begin
                v = (w >> (16 * (bo / 2))) & 32'hFFFF;
                if (sg && v[15]) v = v | 32'hFFFF_0000;
            end
            exp_rsp_data.push_back(v);
            exp_rsp_err.push_back(1'b0);
            lat = 2;
        end else begin
            if (sz >= 2'd2) begin
                v   = d;
                lat = 2;
            end else begin
                mask = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
                sh   = (sz == 2'd0) ? 8 * bo : 16 * (bo / 2);
                v    = (w & ~(mask << sh)) | ((d & mask) << sh);
                lat  = 3;
            end
            exp_wr_addr.push_back({a[31:2], 2'b00});
            exp_wr_data.push_back(v);
            if (commit) ref_mem[idx] = v;
            exp_rsp_data.push_back(32'd0);
            exp_rsp_err.push_back(1'b0);
        end
    endfunction

    // Single compare process: response payload, write strobes, and quiet outputs each cycle
    always @(negedge clock) begin
        if (started && !reset) begin
            if (rspValid) begin
                chk("rsp_reqReady_low", {31'd0, reqReady}, 32'd0);
                chk("rsp_dm_quiet", dmAddress | dmWriteInput | {31'd0, dmWriteEnabled}, 32'd0);
                if (exp_rsp_data.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_response: got data %h expected none", rspData);
                end else begin
                    chk("rspData", rspData, exp_rsp_data[0]);
                    chk("rspError", {31'd0, rspError}, {31'd0, exp_rsp_err[0]});
                    if (rspReady) begin
                        void'(exp_rsp_data.pop_front());
                        void'(exp_rsp_err.pop_front());
                    end
                end
            end else begin
                chk("idle_rsp_payload", rspData | {31'd0, rspError}, 32'd0);
            end
            if (dmWriteEnabled) begin
                if (exp_wr_addr.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_write: got addr %h data %h expected none", dmAddress, dmWriteInput);
                end else begin
                    chk("dmAddress_wr", dmAddress, exp_wr_addr.pop_front());
                    chk("dmWriteInput", dmWriteInput, exp_wr_data.pop_front());
                end
            end
        end
    end

    task automatic drive_req(input logic wr, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [31:0] d, input bit ready);
        int n;
        bit seen;
        @(posedge clock); #1;
        reqValid = 1'b1; reqWrite = wr; reqSize = sz; reqSigned = sg;
        reqAddress = a; reqWriteData = d; rspReady = ready;
        seen = 0;
        for (n = 0; n < 20; n++) begin
            @(negedge clock);
            if (reqReady) begin seen = 1; break; end
        end
        if (!seen) begin n_cmp++; n_fail++; $display("FAIL accept_timeout: got no reqReady expected reqReady"); end
        @(posedge clock);
        accept_cycle = cycle;
        #1 reqValid = 1'b0;
    endtask

    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d, input int hold,
                         output logic [31:0] got);
        int lat, n;
        model(wr, sz, sg, a, d, 1, lat);
        drive_req(wr, sz, sg, a, d, hold == 0);
        for (n = 1; n <= 10; n++) begin
            @(negedge clock);
            if (rspValid) break;
        end
        chk("latency", n, lat);
        got = rspData;
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clock);
                chk("hold_rspValid", {31'd0, rspValid}, 32'd1);
                chk("hold_reqReady", {31'd0, reqReady}, 32'd0);
            end
            @(posedge clock); #1 rspReady = 1'b1;
        end
    endtask

    logic [31:0] got;
    int prev_accept;
    int lat_dummy;
    bit seen_w;

    initial begin
        reset = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'd0; reqSigned = 1'b0;
        reqAddress = 32'd0; reqWriteData = 32'd0; rspReady = 1'b1;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'h1357_9BDF ^ (i * 32'h0101_0101);
            ref_mem[i] = 32'h1357_9BDF ^ (i * 32'h0101_0101);
        end
        mem[4] = 32'h8899_AABB; ref_mem[4] = 32'h8899_AABB;

        repeat (3) @(posedge clock);
        #2;
        chk("reset_reqReady", {31'd0, reqReady}, 32'd1);
        chk("reset_rspValid", {31'd0, rspValid}, 32'd0);
        chk("reset_rspData", rspData, 32'd0);
        chk("reset_rspError", {31'd0, rspError}, 32'd0);
        chk("reset_dm", dmAddress | dmWriteInput | {31'd0, dmWriteEnabled}, 32'd0);
        @(posedge clock); #1 reset = 1'b0;
        started = 1;

        issue(1'b0, 2'd0, 1'b1, 32'h11, 32'd0, 0, got);
        chk("lit_lb_signed", got, 32'hFFFF_FFAA);
        issue(1'b0, 2'd0, 1'b0, 32'h11, 32'd0, 0, got);
        chk("lit_lb_unsigned", got, 32'h0000_00AA);
        issue(1'b0, 2'd1, 1'b1, 32'h12, 32'd0, 0, got);
        chk("lit_lh_signed", got, 32'hFFFF_8899);
        issue(1'b0, 2'd1, 1'b0, 32'h10, 32'd0, 0, got);
        issue(1'b0, 2'd0, 1'b1, 32'h10, 32'd0, 0, got);

        issue(1'b1, 2'd1, 1'b0, 32'h12, 32'hFFFF_1234, 0, got);
        chk("lit_sh_mem", mem[4], 32'h1234_AABB);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 0, got);
        chk("lit_lw_after_sh", got, 32'h1234_AABB);

        issue(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_007E, 0, got);
        issue(1'b0, 2'd0, 1'b1, 32'h13, 32'd0, 0, got);
        chk("lit_lb_after_sb", got, 32'h0000_007E);
        issue(1'b0, 2'd0, 1'b1, 32'h12, 32'd0, 0, got);
        issue(1'b1, 2'd0, 1'b0, 32'h14, 32'h0000_00F0, 0, got);
        issue(1'b1, 2'd1, 1'b0, 32'h16, 32'h0000_8001, 0, got);
        issue(1'b0, 2'd1, 1'b1, 32'h16, 32'd0, 0, got);
        issue(1'b0, 2'd0, 1'b1, 32'h14, 32'd0, 0, got);

        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEAD_BEEF, 5, got);
        chk("lit_sw_mem", mem[8], 32'hDEAD_BEEF);

        issue(1'b0, 2'd2, 1'b0, 32'h22, 32'd0, 0, got);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("lit_lw_misaligned", got, 32'd0);
`else
        chk("lit_lw_misaligned", got, 32'hDEAD_BEEF);
`endif
        issue(1'b0, 2'd3, 1'b0, 32'h20, 32'd0, 0, got);
        issue(1'b1, 2'd1, 1'b0, 32'h25, 32'h0000_ABCD, 0, got);
        issue(1'b0, 2'd2, 1'b0, 32'h24, 32'd0, 0, got);
        issue(1'b0, 2'd1, 1'b0, 32'hFFFF_FF27, 32'd0, 0, got);

        // reset during the WRITE cycle of a byte store: strobe drops, memory untouched
        model(1'b1, 2'd0, 1'b0, 32'h31, 32'h0000_005A, 0, lat_dummy);
        drive_req(1'b1, 2'd0, 1'b0, 32'h31, 32'h0000_005A, 1'b1);
        seen_w = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clock);
            if (dmWriteEnabled) begin seen_w = 1; break; end
        end
        chk("rst_saw_write", {31'd0, seen_w}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_strobe_dropped", {31'd0, dmWriteEnabled}, 32'd0);
        chk("rst_reqReady", {31'd0, reqReady}, 32'd1);
        chk("rst_rspValid", {31'd0, rspValid}, 32'd0);
        exp_rsp_data.delete(); exp_rsp_err.delete();
        exp_wr_addr.delete();  exp_wr_data.delete();
        @(posedge clock); @(posedge clock); #1 reset = 1'b0;
        chk("lit_rst_mem", mem[12], 32'h1357_9BDF ^ (12 * 32'h0101_0101));
        #1;
        chk("post_rst_reqReady", {31'd0, reqReady}, 32'd1);
        chk("post_rst_rspValid", {31'd0, rspValid}, 32'd0);
        issue(1'b0, 2'd2, 1'b0, 32'h30, 32'd0, 0, got);

        // back-to-back loads: one accept every three cycles
        prev_accept = 0;
        for (int k = 0; k < 4; k++) begin
            issue(1'b0, 2'd0, k[0], 32'h10 + k, 32'd0, 0, got);
            if (k > 0) chk("accept_spacing", accept_cycle - prev_accept, 32'd3);
            prev_accept = accept_cycle;
        end

        repeat (3) @(negedge clock);
        for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);
        chk("rsp_queue_drained", exp_rsp_data.size(), 32'd0);
        chk("wr_queue_drained", exp_wr_addr.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
